mux_rr_merge: RTL and testbench

MUX_RR_MERGE -- requirements
Module: mux_rr_merge

---
 rtl/mux_rr_merge.sv | 115 +++++++++++
 tb/tb_mux_rr_merge.sv | 156 +++++++++++++++
 2 files changed

// File: rtl/mux_rr_merge.sv
// Two-lane FIFO merge with round-robin output register; optional drop counter under MUX_RR_MERGE_DROP_CNT_EN.
// Latency: one cycle from lane write to valid_out; ready_in low holds the output word, and full lanes drop new words.
module mux_rr_merge #(
    parameter int DEPTH = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] data_in0,
    input  logic       valid_in0,
    input  logic [7:0] data_in1,
    input  logic       valid_in1,
    input  logic       ready_in,
    output logic [7:0] data_out,
    output logic       valid_out,
    output logic       full0,
    output logic       full1,
    output logic       empty0,
    output logic       empty1,
    output logic       overflow0,
    output logic       overflow1,
    output logic [7:0] drop_count
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
    localparam logic [AW-1:0] PTR_ONE  = AW'(1);

    logic [7:0]    mem     [2][DEPTH];
    logic [AW-1:0] wptr    [2];
    logic [AW-1:0] rptr    [2];
    logic [CW-1:0] cnt     [2];
    logic [CW-1:0] cnt_nxt [2];
    logic [7:0]    din     [2];
    logic [1:0]    full_q, empty_q, ovf_q;
    logic [1:0]    vin, wr, drop, pop;
    logic          last_grant, grant, load;

    assign din[0] = data_in0;
    assign din[1] = data_in1;
    assign vin    = {valid_in1, valid_in0};

    // Full is judged on the registered flag, so a same-edge pop cannot rescue a write.
    always_comb begin
        wr    = vin & ~full_q;
        drop  = vin & full_q;
        load  = (~valid_out | ready_in) & ~(&empty_q);
        grant = (empty_q == 2'b00) ? ~last_grant : empty_q[0];
        pop   = load ? (grant ? 2'b10 : 2'b01) : 2'b00;
        for (int l = 0; l < 2; l++) begin
            cnt_nxt[l] = cnt[l] + CW'(wr[l]) - CW'(pop[l]);
        end
    end

    always_ff @(posedge clk) begin
        for (int l = 0; l < 2; l++) begin
            if (wr[l]) mem[l][wptr[l]] <= din[l];
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int l = 0; l < 2; l++) begin
                wptr[l] <= '0;
                rptr[l] <= '0;
                cnt[l]  <= '0;
            end
            full_q     <= 2'b00;
            empty_q    <= 2'b11;
            ovf_q      <= 2'b00;
            last_grant <= 1'b1;
            data_out   <= 8'h00;
            valid_out  <= 1'b0;
        end else begin
            for (int l = 0; l < 2; l++) begin
                if (wr[l])   wptr[l] <= wptr[l] + PTR_ONE;
                if (pop[l])  rptr[l] <= rptr[l] + PTR_ONE;
                if (drop[l]) ovf_q[l] <= 1'b1;
                cnt[l]     <= cnt_nxt[l];
                full_q[l]  <= (cnt_nxt[l] == FULL_CNT);
                empty_q[l] <= (cnt_nxt[l] == '0);
            end
            if (load) begin
                data_out   <= mem[grant][rptr[grant]];
                valid_out  <= 1'b1;
                last_grant <= grant;
            end else if (ready_in) begin
                valid_out  <= 1'b0;
            end
        end
    end

    assign full0     = full_q[0];
    assign full1     = full_q[1];
    assign empty0    = empty_q[0];
    assign empty1    = empty_q[1];
    assign overflow0 = ovf_q[0];
    assign overflow1 = ovf_q[1];

`ifdef MUX_RR_MERGE_DROP_CNT_EN
    logic [8:0] drop_sum;
    logic [7:0] drop_cnt_q;

    assign drop_sum = {1'b0, drop_cnt_q} + 9'(drop[0]) + 9'(drop[1]);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) drop_cnt_q <= 8'h00;
        else       drop_cnt_q <= drop_sum[8] ? 8'hFF : drop_sum[7:0];
    end

    assign drop_count = drop_cnt_q;
`else
    assign drop_count = 8'h00;
`endif

endmodule

// File: tb/tb_mux_rr_merge.sv
// Directed table-driven bench for mux_rr_merge (DEPTH=4), plus reset and saturation sequences.
module tb_mux_rr_merge;
    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [7:0] data_in0 = 8'h00, data_in1 = 8'h00;
    logic       valid_in0 = 1'b0, valid_in1 = 1'b0, ready_in = 1'b0;
    logic [7:0] data_out, drop_count;
    logic       valid_out, full0, full1, empty0, empty1, overflow0, overflow1;

    int n_pass = 0;
    int n_tot  = 0;

`ifdef MUX_RR_MERGE_DROP_CNT_EN
    localparam logic [7:0] D1 = 8'd1, D2 = 8'd2, D31 = 8'd31, DSAT = 8'd255;
`else
    localparam logic [7:0] D1 = 8'd0, D2 = 8'd0, D31 = 8'd0, DSAT = 8'd0;
`endif

    always #5 clk = ~clk;

    mux_rr_merge #(.DEPTH(4)) dut (
        .clk(clk), .reset(reset),
        .data_in0(data_in0), .valid_in0(valid_in0),
        .data_in1(data_in1), .valid_in1(valid_in1),
        .ready_in(ready_in),
        .data_out(data_out), .valid_out(valid_out),
        .full0(full0), .full1(full1), .empty0(empty0), .empty1(empty1),
        .overflow0(overflow0), .overflow1(overflow1), .drop_count(drop_count)
    );

    typedef struct {
        logic       rdy;
        logic       v0;
        logic [7:0] d0;
        logic       v1;
        logic [7:0] d1;
        logic       ev;
        logic [7:0] ed;
        logic [1:0] ee;   // {empty1, empty0}
        logic [1:0] ef;   // {full1, full0}
        logic [1:0] eo;   // {overflow1, overflow0}
        logic [7:0] edc;
    } vec_t;

    vec_t vt[$];

    function automatic void add(input logic rdy, input logic v0, input logic [7:0] d0,
                                input logic v1, input logic [7:0] d1, input logic ev,
                                input logic [7:0] ed, input logic [1:0] ee, input logic [1:0] ef,
                                input logic [1:0] eo, input logic [7:0] edc);
        vec_t v;
        v.rdy = rdy; v.v0 = v0; v.d0 = d0; v.v1 = v1; v.d1 = d1;
        v.ev = ev; v.ed = ed; v.ee = ee; v.ef = ef; v.eo = eo; v.edc = edc;
        vt.push_back(v);
    endfunction

    function automatic logic [22:0] obs();
        return {valid_out, data_out, empty1, empty0, full1, full0, overflow1, overflow0, drop_count};
    endfunction

    task automatic chk(input string nm, input logic [22:0] act, input logic [22:0] exp);
        n_tot++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", nm, act, exp);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        valid_in0 = 1'b0; valid_in1 = 1'b0; ready_in = 1'b0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
    endtask

    initial begin
        // Arbitration after reset: lane 0 wins first.
        add(0, 1,8'hA0, 1,8'hB0, 0,8'h00, 2'b00, 2'b00, 2'b00, 8'd0);
        add(0, 1,8'hA1, 1,8'hB1, 1,8'hA0, 2'b00, 2'b00, 2'b00, 8'd0);
        add(0, 0,8'h00, 0,8'h00, 1,8'hA0, 2'b00, 2'b00, 2'b00, 8'd0);
        add(1, 0,8'h00, 0,8'h00, 1,8'hB0, 2'b00, 2'b00, 2'b00, 8'd0);
        add(1, 0,8'h00, 0,8'h00, 1,8'hA1, 2'b01, 2'b00, 2'b00, 8'd0);
        add(1, 0,8'h00, 0,8'h00, 1,8'hB1, 2'b11, 2'b00, 2'b00, 8'd0);
        add(1, 0,8'h00, 0,8'h00, 0,8'hB1, 2'b11, 2'b00, 2'b00, 8'd0);
        // Single lane streaming, one-cycle latency.
        add(1, 1,8'h24, 0,8'h00, 0,8'hB1, 2'b10, 2'b00, 2'b00, 8'd0);
        add(1, 1,8'h81, 0,8'h00, 1,8'h24, 2'b10, 2'b00, 2'b00, 8'd0);
        add(1, 1,8'h09, 0,8'h00, 1,8'h81, 2'b10, 2'b00, 2'b00, 8'd0);
        add(1, 0,8'h00, 0,8'h00, 1,8'h09, 2'b11, 2'b00, 2'b00, 8'd0);
        add(1, 0,8'h00, 0,8'h00, 0,8'h09, 2'b11, 2'b00, 2'b00, 8'd0);
        // Backpressure hold of 0x5C.
        add(0, 1,8'h5C, 0,8'h00, 0,8'h09, 2'b10, 2'b00, 2'b00, 8'd0);
        add(0, 1,8'h5D, 0,8'h00, 1,8'h5C, 2'b10, 2'b00, 2'b00, 8'd0);
        for (int i = 0; i < 3; i++)
            add(0, 0,8'h00, 0,8'h00, 1,8'h5C, 2'b10, 2'b00, 2'b00, 8'd0);
        add(1, 0,8'h00, 0,8'h00, 1,8'h5D, 2'b11, 2'b00, 2'b00, 8'd0);
        add(1, 0,8'h00, 0,8'h00, 0,8'h5D, 2'b11, 2'b00, 2'b00, 8'd0);
        // Lane 1 overflow with ready low, then a drop on a popping edge.
        add(0, 0,8'h00, 1,8'hC1, 0,8'h5D, 2'b01, 2'b00, 2'b00, 8'd0);
        add(0, 0,8'h00, 1,8'hC2, 1,8'hC1, 2'b01, 2'b00, 2'b00, 8'd0);
        add(0, 0,8'h00, 1,8'hC3, 1,8'hC1, 2'b01, 2'b00, 2'b00, 8'd0);
        add(0, 0,8'h00, 1,8'hC4, 1,8'hC1, 2'b01, 2'b00, 2'b00, 8'd0);
        add(0, 0,8'h00, 1,8'hC5, 1,8'hC1, 2'b01, 2'b10, 2'b00, 8'd0);
        add(0, 0,8'h00, 1,8'hC6, 1,8'hC1, 2'b01, 2'b10, 2'b10, D1);
        add(1, 0,8'h00, 1,8'hC7, 1,8'hC2, 2'b01, 2'b00, 2'b10, D2);
        add(1, 0,8'h00, 0,8'h00, 1,8'hC3, 2'b01, 2'b00, 2'b10, D2);
        add(1, 0,8'h00, 0,8'h00, 1,8'hC4, 2'b01, 2'b00, 2'b10, D2);
        add(1, 0,8'h00, 0,8'h00, 1,8'hC5, 2'b11, 2'b00, 2'b10, D2);
        add(1, 0,8'h00, 0,8'h00, 0,8'hC5, 2'b11, 2'b00, 2'b10, D2);

        do_reset();
        chk("reset_state", obs(), {1'b0, 8'h00, 2'b11, 2'b00, 2'b00, 8'd0});

        for (int i = 0; i < vt.size(); i++) begin
            ready_in = vt[i].rdy;
            valid_in0 = vt[i].v0; data_in0 = vt[i].d0;
            valid_in1 = vt[i].v1; data_in1 = vt[i].d1;
            @(posedge clk); #1;
            chk($sformatf("vec%0d", i), obs(),
                {vt[i].ev, vt[i].ed, vt[i].ee, vt[i].ef, vt[i].eo, vt[i].edc});
        end

        // Reset mid-transfer: three words queued in lane 0 and 0x11 held at the output.
        ready_in = 1'b0; valid_in1 = 1'b0; valid_in0 = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            data_in0 = 8'(i * 8'h11);
            @(posedge clk); #1;
        end
        valid_in0 = 1'b0;
        chk("pre_reset_hold", {15'd0, valid_out, data_out}, {15'd0, 1'b1, 8'h11});
        #2 reset = 1'b1;
        #1 chk("async_reset", obs(), {1'b0, 8'h00, 2'b11, 2'b00, 2'b00, 8'd0});
        valid_in0 = 1'b1; data_in0 = 8'h55;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        valid_in0 = 1'b0; valid_in1 = 1'b1; data_in1 = 8'h3F;
        @(posedge clk); #1;
        chk("post_reset_write", obs(), {1'b0, 8'h00, 2'b01, 2'b00, 2'b00, 8'd0});
        valid_in1 = 1'b0;
        @(posedge clk); #1;
        chk("post_reset_first", obs(), {1'b1, 8'h3F, 2'b11, 2'b00, 2'b00, 8'd0});

        // Both lanes drop every edge once full: counts by 2, then saturates.
        do_reset();
        ready_in = 1'b0; valid_in0 = 1'b1; valid_in1 = 1'b1;
        for (int i = 0; i < 20; i++) begin
            data_in0 = 8'(i); data_in1 = 8'(8'h80 + i);
            @(posedge clk); #1;
        end
        chk("dual_drop", obs(), {1'b1, 8'h00, 2'b00, 2'b11, 2'b11, D31});
        repeat (120) @(posedge clk);
        #1 chk("drop_saturate", obs(), {1'b1, 8'h00, 2'b00, 2'b11, 2'b11, DSAT});
        valid_in0 = 1'b0; valid_in1 = 1'b0;

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end
endmodule
